// File: rtl/host_chunk_loader.sv
// host_chunk_loader: byte sequencer between a host byte stream and the chunk buffer.
//
// A host command moves exactly one full chunk, byte 0 first:
//   load   (cmd_dir = 0): host bytes on in_data/in_valid/in_ready become per-byte
//                         buffer writes (host_input, offset, line_read_from_host).
//   unload (cmd_dir = 1): the buffer's combinational bram_to_host port is walked and
//                         streamed out on out_data/out_valid/out_ready.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   cmd_valid/dir/ready   command handshake (ready only while idle)
//   in_data/valid/ready   load byte stream from the host
//   out_data/valid/ready  unload byte stream to the host
//   bram_lock             compute side owns the buffer; all transfers stall
//   host_input, offset,
//   line_read_from_host   buffer write port (offset is the bit index of the byte MSB)
//   bram_to_host          buffer byte at offset (combinational read)
//   chunk_loaded/sent     one-cycle completion pulses
//   busy                  a command is in progress
module host_chunk_loader #(
  parameter int unsigned num_bits = 512,
  parameter int unsigned ofs_bits = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic                cmd_dir,
  output logic                cmd_ready,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                bram_lock,
  output logic [7:0]          host_input,
  output logic [ofs_bits-1:0] offset,
  output logic                line_read_from_host,
  input  logic [7:0]          bram_to_host,
  output logic                chunk_loaded,
  output logic                chunk_sent,
  output logic                busy
);

  localparam int unsigned Bytes = num_bits / 8;
  localparam int unsigned CntW  = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Bytes - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StUnload, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    dir_d               = dir_q;
    cmd_ready           = 1'b0;
    in_ready            = 1'b0;
    out_valid           = 1'b0;
    line_read_from_host = 1'b0;
    chunk_loaded        = 1'b0;
    chunk_sent          = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cnt_d   = '0;
          dir_d   = cmd_dir;
          state_d = cmd_dir ? StUnload : StLoad;
        end
      end
      StLoad: begin
        in_ready            = !bram_lock;
        // The buffer captures on the same edge that advances cnt.
        line_read_from_host = in_valid && !bram_lock;
        if (line_read_from_host) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) state_d = StDone;
        end
      end
      StUnload: begin
        // Retracting out_valid under lock is allowed; the byte is re-offered later.
        out_valid = !bram_lock;
        if (out_valid && out_ready) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) state_d = StDone;
        end
      end
      StDone: begin
        chunk_loaded = !dir_q;
        chunk_sent   = dir_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign offset     = ofs_bits'({cnt_q, 3'b111});
  assign host_input = in_data;
  assign out_data   = bram_to_host;

endmodule

// File: tb/tb_host_chunk_loader.sv
// Bench for host_chunk_loader: emulates the chunk buffer, keeps a transaction-level
// model of the expected outputs, and runs directed load/unload/lock/reset scenarios.
module tb_host_chunk_loader;

  localparam int NumBits = 512;
  localparam int Bytes   = NumBits / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_dir = 1'b0, cmd_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ready = 1'b0;
  logic       bram_lock = 1'b0;
  logic [7:0] host_input;
  logic [8:0] offset;
  logic       line_read_from_host;
  logic [7:0] bram_to_host;
  logic       chunk_loaded, chunk_sent, busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  host_chunk_loader #(.num_bits(NumBits), .ofs_bits(9)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd_valid           (cmd_valid),
    .cmd_dir             (cmd_dir),
    .cmd_ready           (cmd_ready),
    .in_data             (in_data),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .out_data            (out_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .bram_lock           (bram_lock),
    .host_input          (host_input),
    .offset              (offset),
    .line_read_from_host (line_read_from_host),
    .bram_to_host        (bram_to_host),
    .chunk_loaded        (chunk_loaded),
    .chunk_sent          (chunk_sent),
    .busy                (busy)
  );

  // Chunk buffer emulation: byte write at [offset -: 8], combinational read.
  logic [NumBits-1:0] buf_q = '0;
  always @(posedge clk) if (line_read_from_host) buf_q[offset -: 8] <= host_input;
  assign bram_to_host = buf_q[offset -: 8];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: phase 0 idle, 1 loading, 2 unloading, 3 completion cycle;
  // m_idx is the index of the next byte of the chunk.
  int m_phase = 0;
  int m_idx   = 0;
  bit m_dir   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_idx   <= 0;
    end else if (m_phase == 0) begin
      if (cmd_valid) begin
        m_idx   <= 0;
        m_dir   <= cmd_dir;
        m_phase <= cmd_dir ? 2 : 1;
      end
    end else if (m_phase == 3) begin
      m_phase <= 0;
    end else if (!bram_lock && ((m_phase == 1 && in_valid) || (m_phase == 2 && out_ready))) begin
      m_idx <= (m_idx + 1) % Bytes;
      if (m_idx == Bytes - 1) m_phase <= 3;
    end
  end

  always @(negedge clk) begin
    logic [31:0] act, exp;
    if (chk_en) begin
      act = {cmd_ready, busy, in_ready, out_valid, line_read_from_host, chunk_loaded,
             chunk_sent, offset, host_input, out_data};
      exp = {m_phase == 0, m_phase != 0, m_phase == 1 && !bram_lock,
             m_phase == 2 && !bram_lock, m_phase == 1 && !bram_lock && in_valid,
             m_phase == 3 && !m_dir, m_phase == 3 && m_dir, 9'(8 * m_idx + 7), in_data,
             buf_q[8 * m_idx + 7 -: 8]};
      chk("cycle_model", act, exp);
    end
  end

  // Load one chunk of bytes i^key. lock_at/rst_at: byte count at which to apply a
  // 5-cycle bram_lock or a reset (-1 = never). hold_cmd keeps cmd_valid high, dir=1.
  task automatic run_load(input logic [7:0] key, input int lock_at, input int rst_at,
                          input bit hold_cmd);
    int n = 0, strobes = 0, accepts = 0, last_c = -1, done_c = -1;
    bit lock_done = 1'b0, resume = 1'b0, acc;
    in_valid  = 1'b1;
    in_data   = key;
    cmd_dir   = 1'b0;
    cmd_valid = 1'b1;
    tick();
    if (hold_cmd) cmd_dir = 1'b1;
    else cmd_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) accepts++;
      if (resume) begin
        chk("resume_strobe", line_read_from_host, 1);
        chk("resume_offset", offset, 8 * lock_at + 7);
        resume = 1'b0;
      end
      if (line_read_from_host) begin
        strobes++;
        if (strobes == 1) chk("first_strobe_offset", offset, 7);
        if (strobes == Bytes) begin
          chk("last_strobe_offset", offset, 511);
          last_c = c;
        end
      end
      if (chunk_loaded) begin
        done_c = c;
        break;
      end
      acc = line_read_from_host;
      tick();
      if (acc) begin
        n++;
        in_data = 8'(n) ^ key;
      end
      if (n == lock_at && !lock_done) begin
        lock_done = 1'b1;
        bram_lock = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("lock_in_ready", in_ready, 0);
          chk("lock_strobe", line_read_from_host, 0);
          chk("lock_offset", offset, 8 * lock_at + 7);
          tick();
        end
        bram_lock = 1'b0;
        resume    = 1'b1;
      end
      if (n == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_offset", offset, 7);
        chk("rst_strobe", line_read_from_host, 0);
        chk("rst_busy", busy, 0);
        tick();
        in_valid = 1'b0;
        return;
      end
    end
    tick();
    in_valid = 1'b0;
    chk("load_completed", done_c >= 0, 1);
    chk("load_strobes", strobes, Bytes);
    chk("loaded_after_last_byte", done_c - last_c, 1);
    if (hold_cmd) chk("held_cmd_ignored", accepts, 0);
  endtask

  // Unload one chunk and compare against bytes i^key. toggle drives out_ready 1,0,1,0...
  task automatic run_unload(input bit issue, input bit toggle, input logic [7:0] key);
    logic [7:0] got[$];
    int busy_cnt = 0, sent = 0, k = 0, bad = 0, first_c = -1;
    if (issue) begin
      cmd_valid = 1'b1;
      cmd_dir   = 1'b1;
      tick();
      cmd_valid = 1'b0;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (out_valid && first_c < 0) first_c = c;
      if (out_valid && out_ready) got.push_back(out_data);
      if (chunk_sent) begin
        sent++;
        break;
      end
      tick();
      k++;
      if (toggle) out_ready = (k % 2 == 0);
    end
    tick();
    out_ready = 1'b0;
    chk("unload_count", got.size(), Bytes);
    foreach (got[i]) if (got[i] !== (8'(i) ^ key)) bad++;
    chk("unload_bytes", bad, 0);
    chk("chunk_sent_pulses", sent, 1);
    if (toggle) chk("unload_cycles", busy_cnt + 1, 129);
    if (!issue) chk("unload_starts_next_cycle", first_c, 0);
  endtask

  function automatic logic [NumBits-1:0] pattern(input logic [7:0] key);
    logic [NumBits-1:0] p;
    for (int i = 0; i < Bytes; i++) p[8 * i +: 8] = 8'(i) ^ key;
    return p;
  endfunction

  initial begin
    // Reset state.
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_offset", offset, 7);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);
    tick();

    // Plain load 0x00..0x3F.
    run_load(8'h00, -1, -1, 1'b0);
    chk("chunk_after_load", buf_q,
        512'h3F3E3D3C3B3A3938373635343332313_0_2F2E2D2C2B2A292827262524232221_20_1F1E1D1C1B1A191817161514131211_10_0F0E0D0C0B0A0908070605040302_0100);
    chk("pattern_fn_pin", pattern(8'h00) ^ pattern(8'hFF), {Bytes{8'hFF}});

    // Unload with out_ready toggling.
    run_unload(1'b1, 1'b1, 8'h00);

    // Lock for 5 cycles at cnt=20.
    run_load(8'hA5, 20, -1, 1'b0);
    chk("chunk_after_lock_load", buf_q, pattern(8'hA5));
    chk("byte20_after_lock", buf_q[167 -: 8], 8'hB1);

    // Reset at cnt=30, then a fresh load from offset 7.
    run_load(8'h3C, -1, 30, 1'b0);
    run_load(8'h3C, -1, -1, 1'b0);
    chk("chunk_after_reload", buf_q, pattern(8'h3C));

    // cmd_valid held (dir=1) through a load: unload follows right after IDLE.
    run_load(8'h5A, -1, -1, 1'b1);
    @(negedge clk);
    chk("idle_after_done", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    run_unload(1'b0, 1'b0, 8'h5A);

    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
